card_dealer: RTL and testbench

Sequential dealer for the baccarat datapath. It issues card codes into three player and three banker card registers in baccarat dealing order, one card per `deal` request. It applies the third-card rules using hand scores returned by two external `scorehand` instances, then registers the round outcome. It is the producer end of the card interface that `scorehand` consumes.

---
 rtl/card_dealer.sv | 145 ++++++++++++++
 tb/tb_card_dealer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/card_dealer.sv
// Baccarat card dealer: deals player/banker cards in order and applies the third-card rules.
// Define CARD_DEALER_STEP_DECK_EN to advance the card source only on dealt cards (deterministic deck).
module card_dealer (
   input  logic       clk,
   input  logic       resetb,
   input  logic       deal,
   input  logic [3:0] pscore,
   input  logic [3:0] bscore,
   output logic [3:0] pcard1,
   output logic [3:0] pcard2,
   output logic [3:0] pcard3,
   output logic [3:0] bcard1,
   output logic [3:0] bcard2,
   output logic [3:0] bcard3,
   output logic       done,
   output logic       player_win,
   output logic       banker_win
);

   typedef enum logic [3:0] {
      IDLE, P1, B1, P2, B2, CHK, P3, BCHK, B3, DONE
   } state_t;

   state_t     state;
   logic [3:0] src;
   logic [3:0] src_next;
   logic       stood;
   logic [3:0] v3;
   logic       bdraw;
   logic       natural;

   assign src_next = (src == 4'd13) ? 4'd1 : src + 4'd1;
   assign natural  = (pscore >= 4'd8) || (bscore >= 4'd8);
   // Face cards and tens count as zero toward the player's third-card value.
   assign v3       = (pcard3 >= 4'd10) ? 4'd0 : pcard3;

   always_comb begin
      bdraw = 1'b0;
      if (stood) begin
         bdraw = (bscore <= 4'd5);
      end else begin
         case (bscore)
            4'd0, 4'd1, 4'd2: bdraw = 1'b1;
            4'd3:             bdraw = (v3 != 4'd8);
            4'd4:             bdraw = (v3 >= 4'd2) && (v3 <= 4'd7);
            4'd5:             bdraw = (v3 >= 4'd4) && (v3 <= 4'd7);
            4'd6:             bdraw = (v3 >= 4'd6) && (v3 <= 4'd7);
            default:          bdraw = 1'b0;
         endcase
      end
   end

`ifdef CARD_DEALER_STEP_DECK_EN
   logic dealing;
   assign dealing = deal && ((state == P1) || (state == B1) || (state == P2) ||
                             (state == B2) || (state == P3) || (state == B3));

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) src <= 4'd1;
      else if (dealing) src <= src_next;
   end
`else
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) src <= 4'd1;
      else src <= src_next;
   end
`endif

   // deal is a level sampled at each edge; it is only honoured in the six card states and DONE.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         state      <= IDLE;
         stood      <= 1'b0;
         pcard1     <= 4'd0;
         pcard2     <= 4'd0;
         pcard3     <= 4'd0;
         bcard1     <= 4'd0;
         bcard2     <= 4'd0;
         bcard3     <= 4'd0;
         done       <= 1'b0;
         player_win <= 1'b0;
         banker_win <= 1'b0;
      end else begin
         case (state)
            IDLE: state <= P1;
            P1: if (deal) begin pcard1 <= src; state <= B1; end
            B1: if (deal) begin bcard1 <= src; state <= P2; end
            P2: if (deal) begin pcard2 <= src; state <= B2; end
            B2: if (deal) begin bcard2 <= src; state <= CHK; end
            CHK: begin
               if (natural) begin
                  state      <= DONE;
                  done       <= 1'b1;
                  player_win <= (pscore >= bscore);
                  banker_win <= (pscore <= bscore);
               end else if (pscore <= 4'd5) begin
                  stood <= 1'b0;
                  state <= P3;
               end else begin
                  stood <= 1'b1;
                  state <= BCHK;
               end
            end
            P3: if (deal) begin pcard3 <= src; state <= BCHK; end
            BCHK: begin
               if (bdraw) begin
                  state <= B3;
               end else begin
                  state      <= DONE;
                  done       <= 1'b1;
                  player_win <= (pscore >= bscore);
                  banker_win <= (pscore <= bscore);
               end
            end
            B3: begin
               if (deal) begin
                  bcard3     <= src;
                  state      <= DONE;
                  done       <= 1'b1;
                  player_win <= (pscore >= bscore);
                  banker_win <= (pscore <= bscore);
               end
            end
            DONE: begin
               // Restart edge clears the table without dealing a card.
               if (deal) begin
                  pcard1     <= 4'd0;
                  pcard2     <= 4'd0;
                  pcard3     <= 4'd0;
                  bcard1     <= 4'd0;
                  bcard2     <= 4'd0;
                  bcard3     <= 4'd0;
                  done       <= 1'b0;
                  player_win <= 1'b0;
                  banker_win <= 1'b0;
                  stood      <= 1'b0;
                  state      <= P1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_card_dealer.sv
// Directed testbench for card_dealer; tracks the card source itself in either deck mode.
module tb_card_dealer;

   logic       clk = 1'b0;
   logic       resetb = 1'b0;
   logic       deal = 1'b0;
   logic       deal_acc = 1'b0;
   logic [3:0] pscore = 4'd0;
   logic [3:0] bscore = 4'd0;
   logic [3:0] pcard1, pcard2, pcard3, bcard1, bcard2, bcard3;
   logic       done, player_win, banker_win;
   logic [3:0] exp_src;
   int         checks = 0;
   int         failures = 0;

   card_dealer dut (
      .clk(clk), .resetb(resetb), .deal(deal),
      .pscore(pscore), .bscore(bscore),
      .pcard1(pcard1), .pcard2(pcard2), .pcard3(pcard3),
      .bcard1(bcard1), .bcard2(bcard2), .bcard3(bcard3),
      .done(done), .player_win(player_win), .banker_win(banker_win)
   );

   always #5 clk = ~clk;

   // Reference card source: deal_acc marks edges where the bench expects a card to be taken.
   always @(posedge clk or negedge resetb) begin
      if (!resetb) exp_src <= 4'd1;
`ifdef CARD_DEALER_STEP_DECK_EN
      else if (deal_acc) exp_src <= (exp_src == 4'd13) ? 4'd1 : exp_src + 4'd1;
`else
      else exp_src <= (exp_src == 4'd13) ? 4'd1 : exp_src + 4'd1;
`endif
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic banker_rule(input logic [3:0] bs, input logic [3:0] v);
      case (bs)
         4'd0, 4'd1, 4'd2: return 1'b1;
         4'd3:             return v != 4'd8;
         4'd4:             return (v >= 4'd2) && (v <= 4'd7);
         4'd5:             return (v >= 4'd4) && (v <= 4'd7);
         4'd6:             return (v >= 4'd6) && (v <= 4'd7);
         default:          return 1'b0;
      endcase
   endfunction

   task automatic do_reset();
      deal = 1'b0; deal_acc = 1'b0; pscore = 4'd0; bscore = 4'd0;
      resetb = 1'b0;
      repeat (2) @(negedge clk);
      resetb = 1'b1;
      @(negedge clk);
   endtask

   task automatic deal_card(input logic [3:0] target, output logic [3:0] card);
`ifndef CARD_DEALER_STEP_DECK_EN
      int n;
      n = 0;
`endif
      @(negedge clk);
`ifndef CARD_DEALER_STEP_DECK_EN
      while (target != 4'd0 && exp_src != target && n < 13) begin
         @(negedge clk);
         n++;
      end
`endif
      deal = 1'b1; deal_acc = 1'b1; card = exp_src;
      @(posedge clk);
      #1;
      deal = 1'b0; deal_acc = 1'b0;
   endtask

   task automatic restart(input string tag);
      @(negedge clk);
      deal = 1'b1;
      @(posedge clk);
      #1;
      deal = 1'b0; pscore = 4'd0; bscore = 4'd0;
      @(negedge clk);
      checks++;
      if ({pcard1, pcard2, pcard3, bcard1, bcard2, bcard3, done, player_win, banker_win} !== 27'd0) begin
         failures++;
         $display("FAIL restart_%s: cards/outcome=%h done=%b required all zero", tag,
                  {pcard1, pcard2, pcard3, bcard1, bcard2, bcard3}, done);
      end
   endtask

   // Plays one round from P1; t3 aligns the player's third card when the deck free-runs.
   task automatic play_round(input logic [3:0] ps1, bs1, ps2, bs2, psf, bsf, t3,
                             input bit hold_chk, input string tag);
      logic [3:0] c[6];
      logic [3:0] v, ops, obs;
      logic       draw;
      logic [2:0] exp_o;
      for (int i = 0; i < 6; i++) c[i] = 4'd0;
      deal_card(4'd0, c[0]);
      deal_card(4'd0, c[3]);
      deal_card(4'd0, c[1]);
      deal_card(4'd0, c[4]);
      pscore = ps1; bscore = bs1; ops = ps1; obs = bs1; draw = 1'b0;
      if (hold_chk) deal = 1'b1;
      @(negedge clk);
      checks++;
      if ({pcard1, pcard2, bcard1, bcard2, done} !== {c[0], c[1], c[3], c[4], 1'b0}) begin
         failures++;
         $display("FAIL chk_%s: p1 p2 b1 b2 done=%h %h %h %h %b required %h %h %h %h 0", tag,
                  pcard1, pcard2, bcard1, bcard2, done, c[0], c[1], c[3], c[4]);
      end
      @(posedge clk);
      #1;
      deal = 1'b0;
      if (!(ps1 >= 4'd8 || bs1 >= 4'd8)) begin
         if (ps1 <= 4'd5) begin
            deal_card(t3, c[2]);
            pscore = ps2; bscore = bs2; ops = ps2; obs = bs2;
            v = (c[2] >= 4'd10) ? 4'd0 : c[2];
            draw = banker_rule(bs2, v);
         end else begin
            draw = (bs1 <= 4'd5);
         end
         @(posedge clk);
         #1;
         if (draw) begin
            pscore = psf; bscore = bsf; ops = psf; obs = bsf;
            deal_card(4'd0, c[5]);
         end
      end
      @(negedge clk);
      checks++;
      if ({pcard1, pcard2, pcard3, bcard1, bcard2, bcard3} !== {c[0], c[1], c[2], c[3], c[4], c[5]}) begin
         failures++;
         $display("FAIL cards_%s: got %h required %h", tag,
                  {pcard1, pcard2, pcard3, bcard1, bcard2, bcard3}, {c[0], c[1], c[2], c[3], c[4], c[5]});
      end
      exp_o = {1'b1, ops >= obs, ops <= obs};
      checks++;
      if ({done, player_win, banker_win} !== exp_o) begin
         failures++;
         $display("FAIL outcome_%s: done/pw/bw=%b required %b", tag, {done, player_win, banker_win}, exp_o);
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({pcard1, pcard2, pcard3, bcard1, bcard2, bcard3, done, player_win, banker_win} !== 27'd0) begin
         failures++;
         $display("FAIL reset_state: outputs=%h required 0",
                  {pcard1, pcard2, pcard3, bcard1, bcard2, bcard3, done, player_win, banker_win});
      end
   endtask

   task automatic test_deterministic();
      play_round(4'd4, 4'd6, 4'd9, 4'd6, 4'd0, 4'd0, 4'd5, 1'b0, "det");
`ifdef CARD_DEALER_STEP_DECK_EN
      checks++;
      if ({pcard1, bcard1, pcard2, bcard2, pcard3, bcard3} !== 24'h123450) begin
         failures++;
         $display("FAIL det_sequence: got %h required 123450",
                  {pcard1, bcard1, pcard2, bcard2, pcard3, bcard3});
      end
`endif
   endtask

   task automatic test_natural();
      restart("pre_nat");
      play_round(4'd8, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, "natural");
      restart("pre_nat_b");
      play_round(4'd2, 4'd9, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, "natural_banker");
   endtask

   task automatic test_stood();
      restart("pre_stood");
      play_round(4'd6, 4'd5, 4'd0, 4'd0, 4'd6, 4'd7, 4'd0, 1'b0, "stood_draw");
      restart("pre_stood_tie");
      play_round(4'd6, 4'd6, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, "stood_tie");
      restart("pre_stood_7");
      play_round(4'd7, 4'd6, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, "stood_pwin");
   endtask

   task automatic test_third_rule();
      logic [3:0] bs_tab[11] = '{4'd3, 4'd3, 4'd4, 4'd4, 4'd5, 4'd5, 4'd6, 4'd6, 4'd7, 4'd0, 4'd2};
      logic [3:0] t3_tab[11] = '{4'd8, 4'd12, 4'd2, 4'd1, 4'd4, 4'd3, 4'd7, 4'd5, 4'd6, 4'd13, 4'd9};
      for (int i = 0; i < 11; i++) begin
         restart($sformatf("pre_rule%0d", i));
         play_round(4'd3, bs_tab[i], 4'd1, bs_tab[i], 4'd9, 4'd0, t3_tab[i], 1'b0,
                    $sformatf("rule%0d", i));
      end
   endtask

   task automatic test_wrap();
      do_reset();
      play_round(4'd3, 4'd2, 4'd1, 4'd7, 4'd0, 4'd0, 4'd0, 1'b0, "wrap_a");
      restart("wrap_b");
      play_round(4'd3, 4'd2, 4'd1, 4'd7, 4'd0, 4'd0, 4'd0, 1'b0, "wrap_b");
      restart("wrap_c");
      play_round(4'd9, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, "wrap_c");
`ifdef CARD_DEALER_STEP_DECK_EN
      checks++;
      if ({pcard1, bcard1, pcard2, bcard2} !== 16'hBCD1) begin
         failures++;
         $display("FAIL wrap_14th: got %h required bcd1", {pcard1, bcard1, pcard2, bcard2});
      end
`endif
      restart("wrap_end");
   endtask

   task automatic test_reset_mid();
      logic [3:0] c;
      do_reset();
      deal_card(4'd0, c);
      deal_card(4'd0, c);
      deal_card(4'd0, c);
      #2;
      resetb = 1'b0;
      #1;
      checks++;
      if ({pcard1, pcard2, pcard3, bcard1, bcard2, bcard3, done, player_win, banker_win} !== 27'd0) begin
         failures++;
         $display("FAIL reset_mid_async: outputs=%h required 0",
                  {pcard1, pcard2, pcard3, bcard1, bcard2, bcard3, done, player_win, banker_win});
      end
      @(negedge clk);
      resetb = 1'b1;
      @(negedge clk);
      deal_card(4'd0, c);
      @(negedge clk);
      checks++;
      if ({pcard1, bcard1, pcard2} !== {c, 4'd0, 4'd0}) begin
         failures++;
         $display("FAIL reset_mid_first: p1 b1 p2=%h %h %h required %h 0 0", pcard1, bcard1, pcard2, c);
      end
`ifdef CARD_DEALER_STEP_DECK_EN
      checks++;
      if (pcard1 !== 4'd1) begin
         failures++;
         $display("FAIL reset_mid_src: pcard1=%0d required 1", pcard1);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_deterministic();
      test_natural();
      test_stood();
      test_third_rule();
      test_wrap();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
